hrm_sequencer: RTL
==================

# hrm_sequencer

Instruction-cycle controller for the HRM CPU. Sits between the program memory, the opcode-decode ROM and the datapath. Steps each instruction through FETCH/DECODE/EXECUTE, holds the PC and IR strobes, and gates the decoded write enables into single-cycle pulses. Stalls on inbox-empty and outbox-full handshakes, and halts the machine at end-of-input.

## Interface
Parameters:
- PC_W, 8, program counter width (program memory depth = 2^PC_W)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level; leaves IDLE when high
- wR_dec, wM_dec, rIn_dec, wO_dec  in  1 each  decoded strobes from the opcode-decode ROM for the current IR
- branch_dec, ijump_dec  in  1 each  decoded conditional / unconditional jump
- cond_met  in  1  datapath branch condition (zero/negative, selected by the datapath), valid in EXEC
- jmp_addr  in  PC_W  jump target from IR operand field
- inbox_empty  in  1  inbox FIFO has no data
- inbox_eof  in  1  input stream exhausted (no further data will arrive)
- outbox_full  in  1  outbox FIFO cannot accept
- pc  out  PC_W  program counter, addresses program memory
- ir_load  out  1  load IR from program memory data
- wR, wM  out  1 each  gated register / memory write pulses
- inbox_rd  out  1  pop inbox (one-cycle pulse)
- outbox_wr  out  1  push outbox (one-cycle pulse)
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WAIT_IN, WAIT_OUT, HALT.
- IDLE: all strobes low, pc held. start=1 -> FETCH.
- FETCH: ir_load=1 for this cycle. The IR captures mem[pc] at the end of the cycle. -> DECODE.
- DECODE: no strobes; lets the decode ROM settle on the new IR. Decision, evaluated in this order:
  - rIn_dec & inbox_empty & inbox_eof -> HALT
  - rIn_dec & inbox_empty -> WAIT_IN
  - wO_dec & outbox_full -> WAIT_OUT
  - otherwise -> EXEC
- WAIT_IN: strobes low. inbox_eof & inbox_empty -> HALT. !inbox_empty -> EXEC. Else stay.
- WAIT_OUT: strobes low. !outbox_full -> EXEC. Else stay.
- EXEC, exactly one cycle:
  - wR=wR_dec, wM=wM_dec, inbox_rd=rIn_dec, outbox_wr=wO_dec.
  - PC update: if ijump_dec or (branch_dec & cond_met), pc<=jmp_addr; else pc<=pc+1.
  - -> FETCH.
- PC arithmetic is modulo 2^PC_W; pc=2^PC_W-1 with no jump wraps to 0.
- HALT: terminal. All strobes low, halted=1, pc frozen. Only rst_n exits.
- start is ignored outside IDLE.
- A strobe is never asserted outside EXEC, regardless of the *_dec inputs.

## Timing
- Reset values: state=IDLE, pc=0, ir_load=0, wR=0, wM=0, inbox_rd=0, outbox_wr=0, busy=0, halted=0.
- Asynchronous assertion takes effect immediately, including mid-instruction. Any pending EXEC strobe is dropped and pc returns to 0.
- Deassertion is sampled on the next rising edge.
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to strobes except in EXEC.
- Unstalled instruction takes 3 cycles: FETCH, DECODE, EXEC.
- Each WAIT cycle adds 1 cycle. No upper bound is placed on the wait.
- A new pc is visible in the FETCH cycle that follows EXEC.
- The first FETCH occurs the cycle after start is sampled high in IDLE.
- inbox_rd and outbox_wr are exactly one cycle wide, so one element moves per instruction.
- Simultaneous rIn_dec and wO_dec: the inbox check has priority. After WAIT_IN, outbox_full is not re-checked; the decode ROM never sets both.

## Configuration
- HRM_SEQ_PERF_EN: when defined, adds output ports instr_cnt[15:0] and stall_cnt[15:0].
  - instr_cnt increments on each EXEC cycle.
  - stall_cnt increments on each WAIT_IN or WAIT_OUT cycle.
  - Both reset to 0 and saturate at 16'hFFFF.
- When undefined, those ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset then start=1 with NOP-like decode (all *_dec=0): ir_load high at cycles 1, 4, 7; pc steps 0,1,2; wR/wM never high.
- wR_dec=1 at pc=5: wR is a single pulse in the EXEC cycle only, and pc becomes 6 on the next FETCH.
- branch_dec=1, jmp_addr=8'h20: cond_met=0 gives pc=pc+1; cond_met=1 gives pc=8'h20. ijump_dec=1 gives 8'h20 regardless of cond_met.
- rIn_dec=1, inbox_empty=1 for 4 cycles then 0: busy stays 1 and inbox_rd=0 while waiting. inbox_rd pulses once. With PERF_EN, stall_cnt=4 and instr_cnt increments by 1.
- rIn_dec=1, inbox_empty=1, inbox_eof=1: enter HALT with halted=1 and pc frozen. start pulses are ignored; only rst_n low returns to IDLE with pc=0.
- pc=8'hFF with no jump: next pc=0. Assert rst_n low during EXEC: wR drops in the same cycle without waiting for clk.

Source files
------------

// File: rtl/hrm_sequencer.sv
// hrm_sequencer: instruction-cycle controller for the HRM CPU.
// Steps each instruction through FETCH/DECODE/EXEC, stalls on inbox-empty
// and outbox-full, and halts the machine once the input stream is exhausted.
// Optional feature macro: HRM_SEQ_PERF_EN adds the instr_cnt/stall_cnt
// performance counter outputs.
`timescale 1ns/1ps
module hrm_sequencer #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            wR_dec,
  input  logic            wM_dec,
  input  logic            rIn_dec,
  input  logic            wO_dec,
  input  logic            branch_dec,
  input  logic            ijump_dec,
  input  logic            cond_met,
  input  logic [PC_W-1:0] jmp_addr,
  input  logic            inbox_empty,
  input  logic            inbox_eof,
  input  logic            outbox_full,
  output logic [PC_W-1:0] pc,
  output logic            ir_load,
  output logic            wR,
  output logic            wM,
  output logic            inbox_rd,
  output logic            outbox_wr,
  output logic            busy,
`ifdef HRM_SEQ_PERF_EN
  output logic [15:0]     instr_cnt,
  output logic [15:0]     stall_cnt,
`endif
  output logic            halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WAIT_IN,
    S_WAIT_OUT,
    S_HALT
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [PC_W-1:0] r_pc;
  logic            w_take_jump;

  assign pc = r_pc;

  // State register; reset drops straight back to IDLE, killing any EXEC strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and output decode; strobes follow the *_dec inputs only in EXEC.
  always_comb begin
    w_next_state = r_state;
    ir_load      = 1'b0;
    wR           = 1'b0;
    wM           = 1'b0;
    inbox_rd     = 1'b0;
    outbox_wr    = 1'b0;
    busy         = 1'b0;
    halted       = 1'b0;
    w_take_jump  = ijump_dec | (branch_dec & cond_met);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_load      = 1'b1;
        busy         = 1'b1;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        busy = 1'b1;
        if (rIn_dec && inbox_empty && inbox_eof) begin
          w_next_state = S_HALT;
        end else if (rIn_dec && inbox_empty) begin
          w_next_state = S_WAIT_IN;
        end else if (wO_dec && outbox_full) begin
          w_next_state = S_WAIT_OUT;
        end else begin
          w_next_state = S_EXEC;
        end
      end
      S_WAIT_IN: begin
        busy = 1'b1;
        if (inbox_eof && inbox_empty) begin
          w_next_state = S_HALT;
        end else if (!inbox_empty) begin
          w_next_state = S_EXEC;
        end
      end
      S_WAIT_OUT: begin
        busy = 1'b1;
        if (!outbox_full) begin
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        busy         = 1'b1;
        wR           = wR_dec;
        wM           = wM_dec;
        inbox_rd     = rIn_dec;
        outbox_wr    = wO_dec;
        w_next_state = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Program counter advances only at the end of EXEC, wrapping modulo 2^PC_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else if (r_state == S_EXEC) begin
      if (w_take_jump) begin
        r_pc <= jmp_addr;
      end else begin
        r_pc <= r_pc + PC_W'(1);
      end
    end
  end

`ifdef HRM_SEQ_PERF_EN
  logic [15:0] r_instr_cnt;
  logic [15:0] r_stall_cnt;

  assign instr_cnt = r_instr_cnt;
  assign stall_cnt = r_stall_cnt;

  // Saturating counters of executed instructions and handshake stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if ((r_state == S_EXEC) && (r_instr_cnt != 16'hFFFF)) begin
        r_instr_cnt <= r_instr_cnt + 16'd1;
      end
      if (((r_state == S_WAIT_IN) || (r_state == S_WAIT_OUT)) &&
          (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
